// File: rtl/cache_plru_pkg.sv
// -----------------------------------------------------------------------------
// cache_plru_pkg
// Shared definitions for the 8-way tree-PLRU controller:
//   PLRU_W      - width of one per-set PLRU entry (7 tree bits)
//   WAYS_REP    - width of a way index
//   plru_op_e   - request opcode (TOUCH / FILL / PEEK / CLEAR)
//   flush_st_e  - flush sequencer states
//   plru_t      - one PLRU entry
//   way_t       - one way index
//   plru_update - mark a way as most recently used
//   plru_victim - pick the pseudo-least-recently-used way
//
// Tree layout (bit i of the entry):
//   b0 root (0: ways 0-3 were used last, 1: ways 4-7)
//   b1 inside ways 0-3, b2 inside ways 4-7 (0: lower pair)
//   b3..b6 leaves for pairs 0/1, 2/3, 4/5, 6/7 (1: odd way used last)
// -----------------------------------------------------------------------------
package cache_plru_pkg;

   localparam int PLRU_W   = 7;
   localparam int WAYS_REP = 3;

   typedef enum logic [1:0] {
      OP_TOUCH = 2'b00,
      OP_FILL  = 2'b01,
      OP_PEEK  = 2'b10,
      OP_CLEAR = 2'b11
   } plru_op_e;

   typedef enum logic [0:0] {
      FL_IDLE = 1'b0,
      FL_BUSY = 1'b1
   } flush_st_e;

   typedef logic [PLRU_W-1:0]   plru_t;
   typedef logic [WAYS_REP-1:0] way_t;

   // Point every tree node on the path to w towards w; bits off the path keep
   // their previous value.
   function automatic plru_t plru_update(input plru_t p, input way_t w);
      plru_t r;
      r    = p;
      r[0] = w[2];
      if (w[2] == 1'b0) begin
         r[1] = w[1];
         if (w[1] == 1'b0) begin
            r[3] = w[0];
         end else begin
            r[4] = w[0];
         end
      end else begin
         r[2] = w[1];
         if (w[1] == 1'b0) begin
            r[5] = w[0];
         end else begin
            r[6] = w[0];
         end
      end
      return r;
   endfunction

   // Walk the tree away from the most recently used side at every level.
   function automatic way_t plru_victim(input plru_t p);
      way_t v;
      v[2] = ~p[0];
      if (v[2] == 1'b0) begin
         v[1] = ~p[1];
         v[0] = ~(v[1] ? p[4] : p[3]);
      end else begin
         v[1] = ~p[2];
         v[0] = ~(v[1] ? p[6] : p[5]);
      end
      return v;
   endfunction

endpackage

// File: rtl/plru_victim_sel.sv
// -----------------------------------------------------------------------------
// plru_victim_sel
// Purely combinational victim finder for one 7-bit tree-PLRU entry. Kept as
// its own block so the cache miss path can instantiate the same logic.
// Ports:
//   plru_i   in  PLRU_W    PLRU entry of the set being looked up
//   victim_o out WAYS_REP  pseudo-least-recently-used way of that set
// -----------------------------------------------------------------------------
module plru_victim_sel
   import cache_plru_pkg::*;
(
   input  logic [PLRU_W-1:0]   plru_i,
   output logic [WAYS_REP-1:0] victim_o
);

   assign victim_o = plru_victim(plru_i);

endmodule

// File: rtl/cache_plru_ctrl.sv
// -----------------------------------------------------------------------------
// cache_plru_ctrl
// Per-set tree-PLRU state store and controller for an 8-way cache. Requests
// are registered into stage A; stage A reads its set's entry, computes the
// result and commits it (array write + response registers) as soon as the
// response slot is free. One request per cycle, one cycle accept-to-response.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid/_ready, req_op, req_set, req_way   request channel
//   flush / flush_busy                           clear-all pulse and its status
//   rsp_valid/_ready, rsp_way, rsp_set, rsp_plru response channel
// -----------------------------------------------------------------------------
module cache_plru_ctrl #(
   parameter int WAYS     = 8,
   parameter int WAYS_REP = 3,
   parameter int SETS     = 64,
   parameter int SET_W    = $clog2(SETS)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [1:0]                        req_op,
   input  logic [SET_W-1:0]                  req_set,
   input  logic [WAYS_REP-1:0]               req_way,
   input  logic                              flush,
   output logic                              flush_busy,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [WAYS_REP-1:0]               rsp_way,
   output logic [SET_W-1:0]                  rsp_set,
   output logic [cache_plru_pkg::PLRU_W-1:0] rsp_plru
);

   import cache_plru_pkg::*;

   // CLEAR reports the highest way, which is the victim of an all-zero entry.
   localparam logic [WAYS_REP-1:0] CLEAR_WAY = WAYS_REP'(WAYS - 1);

   // PLRU storage
   plru_t                plru_q [SETS];

   // Stage A
   logic                 a_valid_q, a_valid_d;
   plru_op_e             a_op_q,    a_op_d;
   logic [SET_W-1:0]     a_set_q,   a_set_d;
   logic [WAYS_REP-1:0]  a_way_q,   a_way_d;

   // Response registers
   logic                 rsp_valid_q, rsp_valid_d;
   logic [WAYS_REP-1:0]  rsp_way_q,   rsp_way_d;
   logic [SET_W-1:0]     rsp_set_q,   rsp_set_d;
   plru_t                rsp_plru_q,  rsp_plru_d;

   // Flush sequencer
   flush_st_e            fl_state_q, fl_state_d;

   // Combinational
   plru_t                cur_plru_s;
   logic [WAYS_REP-1:0]  victim_s;
   plru_t                res_plru_s;
   logic [WAYS_REP-1:0]  res_way_s;
   logic                 commit_s;
   logic                 accept_s;
   logic                 req_ready_s;
   logic                 flush_clear_s;

   // Stage A reads the array flops directly. A commit writes on the same edge
   // that loads the next request, so back-to-back hits to one set see the
   // updated entry without any forwarding path.
   assign cur_plru_s = plru_q[a_set_q];

   plru_victim_sel u_victim_sel (
      .plru_i   (cur_plru_s),
      .victim_o (victim_s)
   );

   // Stage A result: new PLRU entry and returned way for the held operation
   always_comb begin
      res_plru_s = cur_plru_s;
      res_way_s  = victim_s;
      case (a_op_q)
         OP_TOUCH: begin
            res_plru_s = plru_update(cur_plru_s, a_way_q);
            res_way_s  = a_way_q;
         end
         OP_FILL: begin
            res_plru_s = plru_update(cur_plru_s, victim_s);
            res_way_s  = victim_s;
         end
         OP_PEEK: begin
            res_plru_s = cur_plru_s;
            res_way_s  = victim_s;
         end
         OP_CLEAR: begin
            res_plru_s = '0;
            res_way_s  = CLEAR_WAY;
         end
         default: begin
            res_plru_s = cur_plru_s;
            res_way_s  = victim_s;
         end
      endcase
   end

   // Handshake: commit when the response slot is free or being drained.
   // A flush pulse also holds off acceptance so it wins over a same-cycle request.
   always_comb begin
      commit_s    = a_valid_q && (!rsp_valid_q || rsp_ready);
      req_ready_s = (fl_state_q == FL_IDLE) && !flush && (!a_valid_q || commit_s);
      accept_s    = req_valid && req_ready_s;
   end

   // Flush next state: wait for stage A to drain (or commit), then wipe all sets
   always_comb begin
      fl_state_d    = fl_state_q;
      flush_clear_s = 1'b0;
      case (fl_state_q)
         FL_IDLE: begin
            if (flush) begin
               fl_state_d = FL_BUSY;
            end else begin
               fl_state_d = FL_IDLE;
            end
         end
         FL_BUSY: begin
            // A further flush pulse here is absorbed by the ongoing one.
            if (!a_valid_q || commit_s) begin
               flush_clear_s = 1'b1;
               fl_state_d    = FL_IDLE;
            end else begin
               fl_state_d    = FL_BUSY;
            end
         end
         default: begin
            fl_state_d = FL_IDLE;
         end
      endcase
   end

   // Stage A next state: load on accept, empty after commit, else hold
   always_comb begin
      a_valid_d = a_valid_q;
      a_op_d    = a_op_q;
      a_set_d   = a_set_q;
      a_way_d   = a_way_q;
      if (accept_s) begin
         a_valid_d = 1'b1;
         a_op_d    = plru_op_e'(req_op);
         a_set_d   = req_set;
         a_way_d   = req_way;
      end else if (commit_s) begin
         a_valid_d = 1'b0;
      end else begin
         a_valid_d = a_valid_q;
      end
   end

   // Response next state: load on commit, drop valid once consumed, else hold
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_way_d   = rsp_way_q;
      rsp_set_d   = rsp_set_q;
      rsp_plru_d  = rsp_plru_q;
      if (commit_s) begin
         rsp_valid_d = 1'b1;
         rsp_way_d   = res_way_s;
         rsp_set_d   = a_set_q;
         rsp_plru_d  = res_plru_s;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end else begin
         rsp_valid_d = rsp_valid_q;
      end
   end

   // PLRU array: a flush wipe overrides a commit landing on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            plru_q[s] <= '0;
         end
      end else if (flush_clear_s) begin
         for (int s = 0; s < SETS; s++) begin
            plru_q[s] <= '0;
         end
      end else if (commit_s) begin
         plru_q[a_set_q] <= res_plru_s;
      end
   end

   // Stage A, response and flush state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid_q   <= 1'b0;
         a_op_q      <= OP_TOUCH;
         a_set_q     <= '0;
         a_way_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_way_q   <= '0;
         rsp_set_q   <= '0;
         rsp_plru_q  <= '0;
         fl_state_q  <= FL_IDLE;
      end else begin
         a_valid_q   <= a_valid_d;
         a_op_q      <= a_op_d;
         a_set_q     <= a_set_d;
         a_way_q     <= a_way_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_way_q   <= rsp_way_d;
         rsp_set_q   <= rsp_set_d;
         rsp_plru_q  <= rsp_plru_d;
         fl_state_q  <= fl_state_d;
      end
   end

   assign req_ready  = req_ready_s;
   assign flush_busy = (fl_state_q == FL_BUSY);
   assign rsp_valid  = rsp_valid_q;
   assign rsp_way    = rsp_way_q;
   assign rsp_set    = rsp_set_q;
   assign rsp_plru   = rsp_plru_q;

endmodule

// File: tb/tb_cache_plru_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_plru_ctrl
// Directed and randomized stimulus for cache_plru_ctrl. Expected responses come
// from a heap-indexed tree model of the PLRU rules, evaluated in request
// acceptance order and queued until the matching response is consumed.
// -----------------------------------------------------------------------------
module tb_cache_plru_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [5:0] req_set;
   logic [2:0] req_way;
   logic       flush;
   logic       flush_busy;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [2:0] rsp_way;
   logic [5:0] rsp_set;
   logic [6:0] rsp_plru;

   always #5 clk = ~clk;

   cache_plru_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_set    (req_set),
      .req_way    (req_way),
      .flush      (flush),
      .flush_busy (flush_busy),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_way    (rsp_way),
      .rsp_set    (rsp_set),
      .rsp_plru   (rsp_plru)
   );

   typedef struct {
      logic [2:0] way;
      logic [5:0] set;
      logic [6:0] plru;
   } exp_t;

   exp_t       exp_q[$];
   logic [6:0] model [64];
   int         checks = 0;
   int         errors = 0;
   logic       last_req_ready;
   logic       last_req_fire;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Tree nodes in heap order: node n has children 2n+1 (bit 0) and 2n+2 (bit 1).
   function automatic logic [6:0] m_update(input logic [6:0] p, input int w);
      logic [6:0] r;
      int node;
      int b;
      r = p;
      node = 0;
      for (int lvl = 2; lvl >= 0; lvl--) begin
         b = (w >> lvl) & 1;
         r[node] = (b == 1);
         node = 2 * node + 1 + b;
      end
      return r;
   endfunction

   function automatic int m_victim(input logic [6:0] p);
      int node;
      int v;
      int b;
      node = 0;
      v = 0;
      for (int lvl = 0; lvl < 3; lvl++) begin
         b = p[node] ? 0 : 1;
         v = v * 2 + b;
         node = 2 * node + 1 + b;
      end
      return v;
   endfunction

   function automatic exp_t model_exec(input logic [1:0] op, input logic [5:0] set,
                                       input logic [2:0] way);
      exp_t e;
      logic [6:0] p;
      int v;
      p = model[set];
      v = m_victim(p);
      e.set = set;
      case (op)
         2'b00: begin
            e.way = way;
            model[set] = m_update(p, int'(way));
         end
         2'b01: begin
            e.way = 3'(v);
            model[set] = m_update(p, v);
         end
         2'b10: begin
            e.way = 3'(v);
         end
         default: begin
            e.way = 3'd7;
            model[set] = 7'd0;
         end
      endcase
      e.plru = model[set];
      return e;
   endfunction

   task automatic model_clear();
      for (int s = 0; s < 64; s++) model[s] = 7'd0;
   endtask

   // One clock cycle: drive inputs, evaluate both handshakes at the falling
   // edge, update scoreboard/model, then return 1 time unit after the rising edge.
   task automatic cyc(input logic v, input logic [1:0] op, input logic [5:0] set,
                      input logic [2:0] way, input logic rr, input logic fl);
      exp_t e;
      req_valid = v;
      req_op    = op;
      req_set   = set;
      req_way   = way;
      rsp_ready = rr;
      flush     = fl;
      @(negedge clk);
      last_req_ready = req_ready;
      last_req_fire  = req_valid && req_ready;
      if (rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            check("rsp_spurious", 32'(rsp_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("rsp_way", 32'(rsp_way), 32'(e.way));
            check("rsp_set", 32'(rsp_set), 32'(e.set));
            check("rsp_plru", 32'(rsp_plru), 32'(e.plru));
         end
      end
      if (last_req_fire) exp_q.push_back(model_exec(op, set, way));
      if (fl) model_clear();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 2'b00, 6'd0, 3'd0, 1'b1, 1'b0);
   endtask

   initial begin
      int seq [8];
      int n;
      logic v;
      logic rr;
      logic fl;
      seq = '{7, 3, 5, 1, 6, 2, 4, 0};

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_set   = 6'd0;
      req_way   = 3'd0;
      flush     = 1'b0;
      rsp_ready = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset state
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_way", 32'(rsp_way), 32'd0);
      check("rst_rsp_set", 32'(rsp_set), 32'd0);
      check("rst_rsp_plru", 32'(rsp_plru), 32'd0);
      check("rst_flush_busy", 32'(flush_busy), 32'd0);

      // PEEK of a fresh set, one cycle latency
      cyc(1'b1, 2'b10, 6'd5, 3'd0, 1'b1, 1'b0);
      check("t1_accept", 32'(last_req_fire), 32'd1);
      check("t1_not_yet", 32'(rsp_valid), 32'd0);
      cyc(1'b0, 2'b00, 6'd0, 3'd0, 1'b1, 1'b0);
      check("t1_lat_valid", 32'(rsp_valid), 32'd1);
      check("t1_way", 32'(rsp_way), 32'd7);
      check("t1_plru", 32'(rsp_plru), 32'd0);
      idle(1);

      // TOUCH then PEEK back to back on the same set
      cyc(1'b1, 2'b00, 6'd3, 3'd5, 1'b1, 1'b0);
      cyc(1'b1, 2'b10, 6'd3, 3'd0, 1'b1, 1'b0);
      cyc(1'b0, 2'b00, 6'd0, 3'd0, 1'b1, 1'b0);
      check("t2_peek_plru", 32'(rsp_plru), 32'h21);
      check("t2_peek_way", 32'(rsp_way), 32'd3);
      idle(1);

      // Eight back-to-back FILLs walk every way once
      for (int i = 0; i < 9; i++) begin
         cyc((i < 8), 2'b01, 6'd9, 3'd0, 1'b1, 1'b0);
         if (i >= 1) begin
            check("t3_valid", 32'(rsp_valid), 32'd1);
            check("t3_way", 32'(rsp_way), 32'(seq[i-1]));
         end
      end
      check("t3_final_plru", 32'(rsp_plru), 32'd0);
      idle(1);

      // Response back-pressure
      cyc(1'b1, 2'b00, 6'd20, 3'd2, 1'b0, 1'b0);
      cyc(1'b1, 2'b00, 6'd20, 3'd6, 1'b0, 1'b0);
      check("t4_second_accept", 32'(last_req_fire), 32'd1);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 2'b10, 6'd20, 3'd0, 1'b0, 1'b0);
         check("t4_stall_ready", 32'(last_req_ready), 32'd0);
         check("t4_hold_valid", 32'(rsp_valid), 32'd1);
         check("t4_hold_way", 32'(rsp_way), 32'(exp_q[0].way));
         check("t4_hold_plru", 32'(rsp_plru), 32'(exp_q[0].plru));
      end
      cyc(1'b1, 2'b10, 6'd20, 3'd0, 1'b1, 1'b0);
      check("t4_release_accept", 32'(last_req_fire), 32'd1);
      idle(3);
      check("t4_drained", 32'(exp_q.size()), 32'd0);

      // Flush racing a request
      cyc(1'b1, 2'b00, 6'd40, 3'd1, 1'b1, 1'b0);
      cyc(1'b1, 2'b00, 6'd41, 3'd4, 1'b1, 1'b0);
      cyc(1'b1, 2'b00, 6'd42, 3'd7, 1'b1, 1'b0);
      cyc(1'b1, 2'b10, 6'd40, 3'd0, 1'b1, 1'b1);
      check("t5_flush_prio", 32'(last_req_fire), 32'd0);
      check("t5_busy", 32'(flush_busy), 32'd1);
      n = 0;
      last_req_fire = 1'b0;
      while (!last_req_fire && n < 6) begin
         cyc(1'b1, 2'b10, 6'd40, 3'd0, 1'b1, 1'b0);
         n++;
      end
      check("t5_stall_len", 32'(n >= 2 && n <= 3), 32'd1);
      check("t5_busy_dropped", 32'(flush_busy), 32'd0);
      cyc(1'b1, 2'b10, 6'd41, 3'd0, 1'b1, 1'b0);
      cyc(1'b1, 2'b10, 6'd42, 3'd0, 1'b1, 1'b0);
      check("t5_peek_way", 32'(rsp_way), 32'd7);
      idle(3);

      // Randomized traffic on a few sets to stress same-set hazards
      for (int i = 0; i < 400; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         rr = ($urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 49) == 0);
         cyc(v, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), rr, fl);
      end
      idle(6);
      check("rand_drained", 32'(exp_q.size()), 32'd0);

      // Reset while a response is pending and stage A is occupied
      cyc(1'b1, 2'b00, 6'd3, 3'd1, 1'b0, 1'b0);
      cyc(1'b1, 2'b10, 6'd4, 3'd0, 1'b0, 1'b0);
      req_valid = 1'b0;
      check("t6_pre_valid", 32'(rsp_valid), 32'd1);
      rst_n = 1'b0;
      #2;
      check("t6_rst_valid", 32'(rsp_valid), 32'd0);
      check("t6_rst_plru", 32'(rsp_plru), 32'd0);
      check("t6_rst_ready", 32'(req_ready), 32'd1);
      exp_q.delete();
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int s = 0; s < 64; s++) cyc(1'b1, 2'b10, 6'(s), 3'd0, 1'b1, 1'b0);
      idle(3);
      check("t6_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
